// File: rtl/ef_uart_wb_bridge_pkg.sv
// ef_uart_wb_bridge_pkg: command/reply byte codes and FSM encoding for the UART-to-Wishbone bridge
package ef_uart_wb_bridge_pkg;
  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h45;
  typedef enum logic [2:0] {
    S_IDLE,
    S_DEC,
    S_ADDR,
    S_DATA,
    S_BUS,
    S_RESP,
    S_ERR
  } state_t;
endpackage

// File: rtl/ef_uart_wb_bridge.sv
// ef_uart_wb_bridge: serial command frames from the UART RX path drive single 32-bit Wishbone cycles
module ef_uart_wb_bridge
  import ef_uart_wb_bridge_pkg::*;
#(
  parameter logic [19:0] BYTE_TO = 20'd100000,
  parameter logic [7:0]  WB_TO   = 8'd255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic [31:0] adr_o,
  output logic [31:0] dat_o,
  input  logic [31:0] dat_i,
  output logic [3:0]  sel_o,
  output logic        cyc_o,
  output logic        stb_o,
  output logic        we_o,
  input  logic        ack_i,
  output logic        busy_o
);
  state_t state, state_nx;
  logic [7:0]  cmd;
  logic [1:0]  cnt;
  logic [1:0]  n;
  logic [31:0] adr_s;
  logic [31:0] dat_s;
  logic [31:0] rsp;
  logic [19:0] tmo;
  logic [7:0]  wb_cnt;
  logic        act;
  logic        is_wr;
  logic        last;
  logic        byte_exp;
  logic        wb_exp;

  assign is_wr    = cmd == CMD_WR;
  assign last     = rx_valid_i && cnt == 2'd3;
  assign byte_exp = BYTE_TO != 20'd0 && !rx_valid_i && tmo == BYTE_TO - 20'd1;
  assign wb_exp   = wb_cnt == WB_TO - 8'd1;

  // state register
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) state <= S_IDLE;
    else state <= state_nx;

  // next-state: frame parsing, bus cycle outcome and reply drain
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (rx_valid_i) state_nx = S_DEC;
      S_DEC:  state_nx = (cmd == CMD_WR || cmd == CMD_RD) ? S_ADDR : S_ERR;
      S_ADDR: if (last) state_nx = is_wr ? S_DATA : S_BUS;
              else if (byte_exp) state_nx = S_IDLE;
      S_DATA: if (last) state_nx = S_BUS;
              else if (byte_exp) state_nx = S_IDLE;
      S_BUS:  if (act && ack_i) state_nx = S_RESP;
              else if (act && wb_exp) state_nx = S_ERR;
      S_RESP: if (tx_ready_i && n == 2'd0) state_nx = S_IDLE;
      S_ERR:  state_nx = S_RESP;
      default: state_nx = S_IDLE;
    endcase
  end

  // outputs: bus strobes follow the active-cycle flag, TX valid is the RESP state itself
  always_comb begin
    cyc_o      = act;
    stb_o      = act;
    sel_o      = act ? 4'hF : 4'h0;
    we_o       = act && is_wr;
    busy_o     = state != S_IDLE;
    tx_valid_o = state == S_RESP;
    tx_data_o  = rsp[7:0];
  end

  // datapath: byte assembly, timeouts, bus cycle control and reply shift register
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      cmd    <= '0;
      cnt    <= '0;
      n      <= '0;
      adr_s  <= '0;
      dat_s  <= '0;
      rsp    <= '0;
      tmo    <= '0;
      wb_cnt <= '0;
      act    <= 1'b0;
      adr_o  <= '0;
      dat_o  <= '0;
    end else begin
      if (state == S_IDLE && rx_valid_i) cmd <= rx_data_i;
      tmo <= (state inside {S_ADDR, S_DATA} && !rx_valid_i) ? tmo + 20'd1 : 20'd0;
      if (state == S_IDLE) cnt <= '0;
      if (state inside {S_ADDR, S_DATA} && rx_valid_i) begin
        cnt <= cnt + 2'd1;
        if (state == S_ADDR) adr_s[{cnt, 3'b000} +: 8] <= rx_data_i;
        else dat_s[{cnt, 3'b000} +: 8] <= rx_data_i;
      end
      if (state == S_BUS) begin
        if (!act) begin
          act    <= 1'b1;
          wb_cnt <= '0;
          adr_o  <= adr_s;
          if (is_wr) dat_o <= dat_s;
        end else if (ack_i) begin
          act <= 1'b0;
          rsp <= is_wr ? {24'd0, RSP_OK} : dat_i;
          n   <= is_wr ? 2'd0 : 2'd3;
        end else if (wb_exp) act <= 1'b0;
        else wb_cnt <= wb_cnt + 8'd1;
      end
      if (state == S_ERR) begin
        rsp <= {24'd0, RSP_ERR};
        n   <= '0;
      end
      if (state == S_RESP && tx_ready_i) begin
        rsp <= rsp >> 8;
        n   <= n - 2'd1;
      end
    end
endmodule

// File: tb/tb_ef_uart_wb_bridge.sv
// tb_ef_uart_wb_bridge: directed and randomized frames checked against a frame-level reference model
module tb_ef_uart_wb_bridge;
  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [31:0] adr, dat_w;
  logic [31:0] dat_r = '0;
  logic [3:0]  sel;
  logic        cyc, stb, we;
  logic        ack = 1'b0;
  logic        busy;

  int   tests = 0;
  int   fails = 0;
  int   ack_dly = 0;
  int   wcnt = 0;
  int   cyc_hi = 0;
  int   proto_bad = 0;
  int   rdy_mode = 0;
  int   lat = -1;
  logic [1:0] ph = '0;
  txn_t txq[$];
  logic [7:0] rxq[$];

  ef_uart_wb_bridge #(.BYTE_TO(20'd40), .WB_TO(8'd8)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
    .adr_o(adr), .dat_o(dat_w), .dat_i(dat_r), .sel_o(sel),
    .cyc_o(cyc), .stb_o(stb), .we_o(we), .ack_i(ack), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // slave and TX sink decide at the falling edge what the next rising edge will see
  always @(negedge clk) begin
    tx_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? (ph == 2'd3) : rdy_mode == 2 ? 1'b0 : 1'($urandom_range(0, 1));
    ph = ph + 2'd1;
    if (tx_valid && tx_ready) rxq.push_back(tx_data);
    if (cyc) begin
      cyc_hi++;
      if (stb !== 1'b1 || sel !== 4'hF) proto_bad++;
      if (wcnt == ack_dly) begin
        ack = 1'b1;
        txq.push_back('{we, adr, dat_w});
      end else ack = 1'b0;
      wcnt++;
    end else begin
      ack = 1'b0;
      wcnt = 0;
      if (stb !== 1'b0 || sel !== 4'h0 || we !== 1'b0) proto_bad++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge clk);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] a, input logic [31:0] d, input int nbytes);
    logic [7:0] f[$];
    f = {cmd};
    for (int i = 0; i < 4; i++) f.push_back(a[8*i +: 8]);
    for (int i = 0; i < 4; i++) f.push_back(d[8*i +: 8]);
    for (int i = 0; i < nbytes; i++) send(f[i], $urandom_range(0, 3));
  endtask

  // reference model: a frame either makes one bus transfer plus its reply, or only an 'E' reply
  task automatic check_frame(input string tag, input logic [7:0] cmd, input logic [31:0] a,
                             input logic [31:0] d, input logic [31:0] rd, input int dly);
    bit         is_w, is_bus;
    int         exp_cyc;
    logic [7:0] exp_rsp[$];
    is_w    = cmd == 8'h57;
    is_bus  = is_w || cmd == 8'h52;
    exp_cyc = !is_bus ? 0 : dly < 0 ? 8 : dly + 1;
    if (!is_bus || dly < 0) exp_rsp = {8'h45};
    else if (is_w) exp_rsp = {8'h4B};
    else for (int i = 0; i < 4; i++) exp_rsp.push_back(rd[8*i +: 8]);
    txq.delete();
    rxq.delete();
    cyc_hi  = 0;
    ack_dly = dly;
    dat_r   = rd;
    send_frame(cmd, a, d, !is_bus ? 1 : is_w ? 9 : 5);
    lat = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (tx_valid && lat < 0) lat = i + 1;
      if (!busy) break;
    end
    chk({tag, " done"}, 32'(busy), 32'd0);
    chk({tag, " txns"}, txq.size(), (is_bus && dly >= 0) ? 32'd1 : 32'd0);
    chk({tag, " cyc_cycles"}, cyc_hi, exp_cyc);
    if (txq.size() == 1) begin
      chk({tag, " adr"}, txq[0].adr, a);
      chk({tag, " we"}, 32'(txq[0].we), 32'(is_w));
      if (is_w) chk({tag, " dat"}, txq[0].dat, d);
    end
    chk({tag, " rsp_len"}, rxq.size(), exp_rsp.size());
    for (int i = 0; i < exp_rsp.size() && i < rxq.size(); i++) chk({tag, " rsp_byte"}, 32'(rxq[i]), 32'(exp_rsp[i]));
  endtask

  initial begin
    logic [7:0] c;
    repeat (3) @(negedge clk);
    chk("rst cyc", 32'(cyc), 32'd0);
    chk("rst tx_valid", 32'(tx_valid), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst adr", adr, 32'd0);
    chk("rst dat", dat_w, 32'd0);
    chk("rst sel_we_tx", {19'd0, sel, we, tx_data}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    check_frame("t1 write", 8'h57, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 0);
    chk("t1 latency", lat, 32'd2);
    chk("t1 adr_hold", adr, 32'h0000_0100);
    chk("t1 dat_hold", dat_w, 32'hDEAD_BEEF);

    rdy_mode = 1;
    check_frame("t2 read_stall", 8'h52, 32'h0000_0004, 32'h0, 32'h1234_5678, 0);
    chk("t2 latency", lat, 32'd2);
    rdy_mode = 0;

    check_frame("t3 bad_cmd", 8'h41, 32'h0, 32'h0, 32'h0, 0);
    check_frame("t3 read_after", 8'h52, 32'hA5A5_0010, 32'h0, 32'hCAFE_F00D, 2);

    check_frame("t4 no_ack", 8'h52, 32'h0000_0008, 32'h0, 32'h1111_2222, -1);

    txq.delete();
    rxq.delete();
    cyc_hi = 0;
    ack_dly = 0;
    send(8'h52, 0);
    send(8'h04, 0);
    send(8'h00, 0);
    repeat (60) @(negedge clk);
    chk("t5 idle busy", 32'(busy), 32'd0);
    chk("t5 no_cyc", cyc_hi, 32'd0);
    chk("t5 no_reply", rxq.size(), 32'd0);
    check_frame("t5 follow", 8'h57, 32'h2000_0040, 32'h0BAD_CAFE, 32'h0, 1);

    ack_dly = -1;
    send_frame(8'h52, 32'h0000_0030, 32'h0, 5);
    for (int i = 0; i < 50 && !cyc; i++) @(negedge clk);
    chk("t6 bus_reached", 32'(cyc), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6 bus_rst cyc", 32'(cyc), 32'd0);
    chk("t6 bus_rst busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rdy_mode = 2;
    ack_dly = 0;
    send_frame(8'h57, 32'h0000_0050, 32'h5555_AAAA, 9);
    for (int i = 0; i < 50 && !tx_valid; i++) @(negedge clk);
    chk("t6 resp_reached", 32'(tx_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6 resp_rst tx_valid", 32'(tx_valid), 32'd0);
    chk("t6 resp_rst busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rdy_mode = 0;
    check_frame("t6 after_rst", 8'h57, 32'h0000_0060, 32'h8765_4321, 32'h0, 0);

    for (int k = 0; k < 24; k++) begin
      int r;
      r = $urandom_range(0, 9);
      c = r < 4 ? 8'h57 : r < 8 ? 8'h52 : 8'($urandom_range(0, 255));
      if (r >= 8 && (c == 8'h57 || c == 8'h52)) c = 8'h00;
      rdy_mode = $urandom_range(0, 2) == 2 ? 3 : $urandom_range(0, 1);
      check_frame("rnd", c, $urandom, $urandom, $urandom, $urandom_range(0, 4));
    end
    rdy_mode = 0;

    chk("protocol", proto_bad, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
